uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: BAUD_CYCLES, default 35, clocks per bit period (matches transmitter bit timing).
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 RX  input  1  serial line, idle high, asynchronous to clk.
REQ-005 clr_rdy  input  1  single-cycle pulse acknowledging rx_data.
REQ-006 rx_data  output  8  last received byte.
REQ-007 rdy  output  1  high when rx_data holds an unacknowledged byte.
REQ-008 framing_err  output  1  stop bit sampled low (present only with UART_RX_FRAMING_CHECK_EN).

Function
REQ-009 The block SHALL pass RX through a two-flop synchronizer, preset to 1, before any use; rx_s denotes the synchronizer output.
REQ-010 Frame format SHALL be: 1 start (0), 8 data LSB first, 1 stop (1); no parity.
REQ-011 The FSM SHALL have states IDLE and RECV (typedef in package).
REQ-012 IDLE->RECV SHALL occur when rx_s==0; the baud counter loads BAUD_CYCLES/2 (integer divide) and the bit counter loads 0.
REQ-013 In RECV the baud counter SHALL decrement each clk; at 0 it SHALL sample rx_s, right-shift it into a 9-bit shift register, increment the bit counter, and reload BAUD_CYCLES-1.
REQ-014 Sample 0 (start, mid-bit) reading 1 SHALL be a false start: return to IDLE, rdy and rx_data unchanged.
REQ-015 After sample 9 (stop) the FSM SHALL return to IDLE; rx_data SHALL load data bits and rdy SHALL set on the next clk edge.
REQ-016 rdy SHALL clear on clr_rdy or on IDLE->RECV transition; when set and clear coincide, set SHALL win.
REQ-017 A new byte arriving while rdy is high SHALL overwrite rx_data (no overrun flag).
REQ-018 Counters SHALL be sized by $clog2(BAUD_CYCLES) and 4 bits; no wrap-around reachable in legal operation.
REQ-019 Nominal latency: rdy rises BAUD_CYCLES/2 + 9*BAUD_CYCLES + 3 clks (+/-1) after RX falling edge.
REQ-020 The FSM SHALL ignore RX until back in IDLE; a stop bit followed immediately by a start bit SHALL be received back-to-back.

Reset
REQ-021 On rst: state=IDLE, rx_data=8'h00, rdy=0, framing_err=0, synchronizer flops=1, counters=0, shift register=all ones.
REQ-022 rst asserted mid-frame SHALL abort the frame; no rdy pulse for that frame after rst release.

Configuration
REQ-023 Macro UART_RX_FRAMING_CHECK_EN: when defined, stop sample 0 SHALL set framing_err, SHALL NOT set rdy, SHALL NOT update rx_data; framing_err clears on clr_rdy or next IDLE->RECV.
REQ-024 Without UART_RX_FRAMING_CHECK_EN: port framing_err is absent; the stop sample is ignored and rdy sets regardless.

Structure
REQ-025 Package uart_pkg SHALL hold the rx state typedef, UART_DATA_BITS=8, and UART_FRAME_BITS=10.
REQ-026 Sub-module uart_sync2 (two-flop synchronizer, parameterized reset value) SHALL be instantiated for RX.

Verification
REQ-027 Transmit 8'hA5 at 35 clk/bit -> rdy rises ~335 clks after start edge, rx_data=8'hA5.
REQ-028 RX low for 5 clks then high -> no rdy, FSM back in IDLE by clk ~20.
REQ-029 Frames 8'h00 then 8'hFF back-to-back, no clr_rdy -> rdy clears at second start, sets again, rx_data=8'hFF.
REQ-030 rdy high, clr_rdy pulse -> rdy low next clk; clr_rdy on same clk as rdy set -> rdy high.
REQ-031 With macro: 8'h3C frame with stop=0 -> framing_err=1, rdy=0, rx_data unchanged; without macro -> rdy=1, rx_data=8'h3C.
REQ-032 rst pulse mid-frame (after bit 4) -> all outputs reset value, no rdy; next clean frame 8'h5A received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver types and frame-size constants.
package uart_pkg;

  // Receiver FSM states
  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FRAME_BITS = 10;  // start + data + stop

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops take RESET_VAL on reset so the idle level is seen from reset onward.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops resolve metastability before the signal fans out
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule : uart_sync2

// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, mid-bit sampling, BAUD_CYCLES clocks per bit.
// Optional feature macro: UART_RX_FRAMING_CHECK_EN adds the framing_err output and
// rejects frames whose stop bit samples low.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_CYCLES = 35
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RX,
  input  logic                      clr_rdy,
  output logic [UART_DATA_BITS-1:0] rx_data,
`ifdef UART_RX_FRAMING_CHECK_EN
  output logic                      framing_err,
`endif
  output logic                      rdy
);

  localparam int unsigned CntW = (BAUD_CYCLES > 1) ? $clog2(BAUD_CYCLES) : 1;
  localparam logic [CntW-1:0] HalfLoad = CntW'(BAUD_CYCLES / 2);
  localparam logic [CntW-1:0] BitLoad  = CntW'(BAUD_CYCLES - 1);
  localparam logic [3:0]      LastBit  = 4'(UART_FRAME_BITS - 1);
`ifdef UART_RX_FRAMING_CHECK_EN
  localparam logic FramingCheck = 1'b1;
`else
  localparam logic FramingCheck = 1'b0;
`endif

  logic                    w_rx_s;
  rx_state_e               r_state;
  rx_state_e               w_state_next;
  logic [CntW-1:0]         r_baud;
  logic [3:0]              r_bit;
  logic [UART_DATA_BITS:0] r_shift;  // data bits plus stop bit in the MSB
  logic                    r_done;   // stop bit sampled last cycle
  logic                    w_start;
  logic                    w_tick;
  logic                    w_false_start;
  logic                    w_last;
  logic                    w_accept;
  logic                    w_clear;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync_rx (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (RX),
    .o_q   (w_rx_s)
  );

  // Decode frame events from the current state and counters
  always_comb begin
    w_start       = (r_state == IDLE) && !w_rx_s;
    w_tick        = (r_state == RECV) && (r_baud == '0);
    w_false_start = w_tick && (r_bit == 4'd0) && w_rx_s;
    w_last        = w_tick && (r_bit == LastBit);
    // Without the framing check the stop bit is ignored and every frame is accepted
    w_accept      = r_done && (r_shift[UART_DATA_BITS] || !FramingCheck);
    w_clear       = clr_rdy || w_start;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (w_start) w_state_next = RECV;
      RECV: if (w_false_start || w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Baud/bit counters and sample shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '1;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_start) begin
        r_baud <= HalfLoad;
        r_bit  <= '0;
      end else if (r_state == RECV) begin
        if (r_baud == '0) begin
          // Start bit is shifted in too; it falls off the LSB by the stop sample
          r_shift <= {w_rx_s, r_shift[UART_DATA_BITS:1]};
          r_bit   <= r_bit + 4'd1;
          r_baud  <= BitLoad;
        end else begin
          r_baud <= r_baud - 1'b1;
        end
      end
    end
  end

  // Output byte and ready flag; a set in the same cycle as a clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data <= '0;
      rdy     <= 1'b0;
    end else if (w_accept) begin
      rx_data <= r_shift[UART_DATA_BITS-1:0];
      rdy     <= 1'b1;
    end else if (w_clear) begin
      rdy <= 1'b0;
    end
  end

`ifdef UART_RX_FRAMING_CHECK_EN
  // Framing error flag, cleared like rdy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      framing_err <= 1'b0;
    end else if (r_done && !r_shift[UART_DATA_BITS]) begin
      framing_err <= 1'b1;
    end else if (w_clear) begin
      framing_err <= 1'b0;
    end
  end
`endif

endmodule : uart_rx
